psum_norm_engine: RTL and testbench

Parametrised normalisation/write-back engine sitting between the output FIFO of the MAC array and the psum memory of a core. It accepts a burst of `ROWS` psum rows and accumulates the absolute sum of every element. It optionally exchanges that sum with a partner core, then divides each element's magnitude by the total with a shared sequential divider. Each normalised row is written to psum memory at an auto-incrementing, wrapping address. It succeeds the fixed 8-column, single-mode SFP path with handshaked input, configurable depth/width, and a self-timed write-back sequence.

---
 rtl/psum_norm_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_psum_norm_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/psum_norm_engine.sv
// psum_norm_engine
//   Collects a burst of ROWS signed psum rows and accumulates the sum of the
//   absolute values of all elements. It can exchange that sum with a partner
//   core. It then divides each element magnitude by the total, using one
//   shared restoring divider, and writes every normalised row to psum memory.
//   The write address auto-increments and wraps.
//
//   Build option: PSUM_NORM_DUAL_CORE_EN
//     Defined   -> XCHG state present; total = own + sum_in (saturating).
//     Undefined -> ACC goes straight to DIV; total = own; sum_in ignored;
//                  sum_out_valid is held 0.
//
// Ports
//   clk, reset (async, active low)
//   start, pmem_base         : begin a burst, first write address
//   in_data/in_valid/in_ready: psum row input handshake
//   sum_in/sum_in_valid      : partner core total
//   sum_out/sum_out_valid    : own total offered to the partner
//   pmem_wr/pmem_add/pmem_d  : psum memory write port
//   busy, done               : status (done is a one-cycle pulse)
module psum_norm_engine #(
  parameter int COL     = 8,
  parameter int BW_PSUM = 20,
  parameter int ROWS    = 8,
  parameter int ADDR_W  = 3,
  parameter int FRAC    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        pmem_base,
  input  logic [BW_PSUM*COL-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BW_PSUM+3:0]       sum_in,
  input  logic                     sum_in_valid,
  output logic [BW_PSUM+3:0]       sum_out,
  output logic                     sum_out_valid,
  output logic                     pmem_wr,
  output logic [ADDR_W-1:0]        pmem_add,
  output logic [BW_PSUM*COL-1:0]   pmem_d,
  output logic                     busy,
  output logic                     done
);

  localparam int SW  = BW_PSUM + 4;
  localparam int DW  = BW_PSUM + FRAC;
  localparam int RSW = BW_PSUM + $clog2(COL + 1);
  localparam int XW  = ((SW > RSW) ? SW : RSW) + 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (COL > 1) ? $clog2(COL) : 1;
  localparam int KW  = $clog2(DW + 1);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_XCHG, S_DIV, S_WB} state_t;

  // Magnitude of a two's-complement element; the most-negative value maps to 2^(BW_PSUM-1).
  function automatic logic [BW_PSUM-1:0] mag(input logic [BW_PSUM-1:0] x);
    mag = x[BW_PSUM-1] ? ((~x) + {{(BW_PSUM-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Add to a total and clamp at all-ones.
  function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [XW-1:0] b);
    logic [XW-1:0] s;
    s = XW'(a) + b;
    if (s > XW'({SW{1'b1}})) sat_add = {SW{1'b1}};
    else                     sat_add = s[SW-1:0];
  endfunction

  state_t                         r_state;
  logic [ROWS-1:0][BW_PSUM*COL-1:0] r_buf;
  logic [RW-1:0]                  r_row;
  logic [CW-1:0]                  r_col;
  logic [KW-1:0]                  r_cnt;
  logic [SW-1:0]                  r_own;
  logic [SW-1:0]                  r_total;
  logic [SW-1:0]                  r_rem;
  logic [DW-1:0]                  r_quo;
  logic [COL-1:0][BW_PSUM-1:0]    r_pd;
  logic [ADDR_W-1:0]              r_addr;
  logic                           r_in_ready;
  logic                           r_sum_out_valid;
  logic                           r_pmem_wr;
  logic                           r_busy;
  logic                           r_done;

  logic [XW-1:0]      w_row_sum;
  logic [SW-1:0]      w_own_next;
  logic [BW_PSUM-1:0] w_elem_mag;
  logic [SW:0]        w_rem_sh;
  logic               w_ge;
  logic [SW-1:0]      w_rem_next;
  logic [DW-1:0]      w_quo_next;

  // Row magnitude sum and the saturating update of the own total.
  always_comb begin
    w_row_sum = '0;
    for (int c = 0; c < COL; c++) begin
      w_row_sum = w_row_sum + XW'(mag(in_data[c*BW_PSUM +: BW_PSUM]));
    end
    w_own_next = sat_add(r_own, w_row_sum);
  end

  // One restoring-division step. The remainder stays below the divisor, so it fits in SW bits.
  always_comb begin
    w_elem_mag = mag(r_buf[r_row][r_col*BW_PSUM +: BW_PSUM]);
    w_rem_sh   = {r_rem, r_quo[DW-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_total});
    if (w_ge) w_rem_next = SW'(w_rem_sh - {1'b0, r_total});
    else      w_rem_next = w_rem_sh[SW-1:0];
    w_quo_next = {r_quo[DW-2:0], w_ge};
  end

`ifndef PSUM_NORM_DUAL_CORE_EN
  logic w_unused;
  assign w_unused = ^{sum_in, sum_in_valid};
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_buf           <= '0;
      r_row           <= '0;
      r_col           <= '0;
      r_cnt           <= '0;
      r_own           <= '0;
      r_total         <= '0;
      r_rem           <= '0;
      r_quo           <= '0;
      r_pd            <= '0;
      r_addr          <= '0;
      r_in_ready      <= 1'b0;
      r_sum_out_valid <= 1'b0;
      r_pmem_wr       <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_ACC;
            r_own      <= '0;
            r_row      <= '0;
            r_addr     <= pmem_base;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_ACC: begin
          if (in_valid) begin
            r_buf[r_row] <= in_data;
            r_own        <= w_own_next;
            if (r_row == RW'(ROWS - 1)) begin
              r_row      <= '0;
              r_col      <= '0;
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
`ifdef PSUM_NORM_DUAL_CORE_EN
              r_sum_out_valid <= 1'b1;
              r_state         <= S_XCHG;
`else
              r_total <= w_own_next;
              r_state <= S_DIV;
`endif
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        S_XCHG: begin
`ifdef PSUM_NORM_DUAL_CORE_EN
          if (sum_in_valid) begin
            r_total         <= sat_add(r_own, XW'(sum_in));
            r_sum_out_valid <= 1'b0;
            r_state         <= S_DIV;
          end
`else
          r_state <= S_IDLE;
`endif
        end
        S_DIV: begin
          if (r_cnt == '0) begin
            // Load cycle: dividend is the magnitude scaled by 2^FRAC.
            r_rem <= '0;
            r_quo <= {w_elem_mag, {FRAC{1'b0}}};
            r_cnt <= {{(KW-1){1'b0}}, 1'b1};
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            if (r_cnt == KW'(DW)) begin
              r_pd[r_col] <= (r_total == '0) ? '0 : w_quo_next[BW_PSUM-1:0];
              r_cnt       <= '0;
              if (r_col == CW'(COL - 1)) begin
                r_col     <= '0;
                r_pmem_wr <= 1'b1;
                r_state   <= S_WB;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_WB: begin
          r_pmem_wr <= 1'b0;
          r_addr    <= r_addr + 1'b1;
          if (r_row == RW'(ROWS - 1)) begin
            r_row   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_row   <= r_row + 1'b1;
            r_state <= S_DIV;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign sum_out       = r_own;
  assign sum_out_valid = r_sum_out_valid;
  assign pmem_wr       = r_pmem_wr;
  assign pmem_add      = r_addr;
  assign pmem_d        = r_pd;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_psum_norm_engine.sv
module tb_psum_norm_engine;
  localparam int COL = 8, BW = 20, ROWS = 2, AW = 3, FRAC = 8, SW = BW + 4;
  localparam longint SAT = (64'd1 << SW) - 1;

  logic clk = 1'b0;
  logic reset, start, in_valid, sum_in_valid;
  logic [AW-1:0] pmem_base;
  logic [BW*COL-1:0] in_data;
  logic [SW-1:0] sum_in;
  logic in_ready, sum_out_valid, pmem_wr, busy, done;
  logic [SW-1:0] sum_out;
  logic [AW-1:0] pmem_add;
  logic [BW*COL-1:0] pmem_d;

  psum_norm_engine #(.COL(COL), .BW_PSUM(BW), .ROWS(ROWS), .ADDR_W(AW), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .start(start), .pmem_base(pmem_base),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .sum_in_valid(sum_in_valid),
    .sum_out(sum_out), .sum_out_valid(sum_out_valid),
    .pmem_wr(pmem_wr), .pmem_add(pmem_add), .pmem_d(pmem_d),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  longint elems [ROWS][COL];
  logic [AW-1:0]     wr_addr_q [$];
  logic [BW*COL-1:0] wr_data_q [$];
  bit prev_wr = 1'b0;

  // Write monitor: collects writes, checks write spacing and the done pulse.
  always @(negedge clk) begin
    if (pmem_wr) begin
      check("wr_gap", {63'd0, prev_wr}, 64'd0);
      wr_addr_q.push_back(pmem_add);
      wr_data_q.push_back(pmem_d);
    end
    if (done) begin
      check("done_after_wb", {63'd0, prev_wr}, 64'd1);
      check("busy_at_done", {63'd0, busy}, 64'd0);
    end
    prev_wr = pmem_wr;
  end

  function automatic longint mag(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint own_total();
    longint s = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COL; c++) s += mag(elems[r][c]);
    return (s > SAT) ? SAT : s;
  endfunction

  function automatic logic [BW*COL-1:0] pack_row(input int r);
    logic [BW*COL-1:0] d;
    longint v;
    for (int c = 0; c < COL; c++) begin
      v = elems[r][c];
      d[c*BW +: BW] = v[BW-1:0];
    end
    return d;
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COL; c++)
        case (mode)
          0: elems[r][c] = 1;
          1: elems[r][c] = (c % 2 == 0) ? 4 : -4;
          2: elems[r][c] = 0;
          3: elems[r][c] = ($urandom_range(0, 3) == 0) ? -(longint'(1) << (BW - 1))
                         : longint'($urandom_range(0, (1 << BW) - 1)) - (longint'(1) << (BW - 1));
          default: elems[r][c] = longint'($urandom_range(0, 200)) - 100;
        endcase
  endtask

  task automatic run_burst(input logic [AW-1:0] base, input longint partner,
                           input bit toggle, input bit restart, input bit do_reset);
    longint own, tot, q;
    logic [BW*COL-1:0] d;
    bit got;
    int r;
    own = own_total();
`ifdef PSUM_NORM_DUAL_CORE_EN
    tot = own + partner;
    if (tot > SAT) tot = SAT;
`else
    tot = own;
`endif
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    start = 1'b1;
    pmem_base = base;
    @(negedge clk);
    start = 1'b0;
    pmem_base = AW'($urandom);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("in_ready_after_start", {63'd0, in_ready}, 64'd1);
    r = 0;
    while (r < ROWS) begin
      if (toggle && ($urandom_range(0, 1) == 0)) begin
        in_valid = 1'b0;
        in_data = {5{$urandom}};
      end else begin
        in_valid = 1'b1;
        in_data = pack_row(r);
        r++;
      end
      @(negedge clk);
    end
    in_valid = toggle;
    in_data = {5{$urandom}};
    check("in_ready_after_last", {63'd0, in_ready}, 64'd0);
`ifdef PSUM_NORM_DUAL_CORE_EN
    check("sum_out_valid", {63'd0, sum_out_valid}, 64'd1);
    check("sum_out_xchg", {40'd0, sum_out}, own);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check("sum_out_valid_hold", {63'd0, sum_out_valid}, 64'd1);
    sum_in_valid = 1'b1;
    sum_in = partner[SW-1:0];
    @(negedge clk);
    sum_in_valid = 1'b0;
    sum_in = SW'($urandom);
`else
    check("sum_out_valid_single", {63'd0, sum_out_valid}, 64'd0);
`endif
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (i == 3) in_valid = 1'b0;
      if (restart && i == 40) begin
        start = 1'b1;
        pmem_base = AW'($urandom);
      end
      if (restart && i == 41) start = 1'b0;
      if (do_reset && i == 100) begin
        reset = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_pmem_wr", {63'd0, pmem_wr}, 64'd0);
        check("rst_pmem_add", {61'd0, pmem_add}, 64'd0);
        check("rst_pmem_d_or", {63'd0, |pmem_d}, 64'd0);
        check("rst_sum_out", {40'd0, sum_out}, 64'd0);
        check("rst_sum_out_valid", {63'd0, sum_out_valid}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        check("rst_no_write", wr_addr_q.size(), 64'd0);
        return;
      end
    end
    check("done_timeout", {63'd0, got}, 64'd1);
    check("sum_out_hold", {40'd0, sum_out}, own);
    check("write_count", wr_addr_q.size(), ROWS);
    for (int w = 0; w < ROWS && w < wr_addr_q.size(); w++) begin
      check("wr_addr", {61'd0, wr_addr_q[w]}, {61'd0, AW'(base + w)});
      d = wr_data_q[w];
      for (int c = 0; c < COL; c++) begin
        q = (tot == 0) ? 0 : (((mag(elems[w][c]) << FRAC) / tot) & ((longint'(1) << BW) - 1));
        check($sformatf("elem_r%0d_c%0d", w, c), {44'd0, d[c*BW +: BW]}, q);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    sum_in_valid = 1'b0;
    pmem_base = '0;
    in_data = '0;
    sum_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd0);
    check("reset_pmem_wr", {63'd0, pmem_wr}, 64'd0);
    check("reset_pmem_add", {61'd0, pmem_add}, 64'd0);
    check("reset_sum_out", {40'd0, sum_out}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    fill(0); run_burst(3'd2, 16, 1'b0, 1'b0, 1'b0);
    fill(1); run_burst(3'd5, 0, 1'b0, 1'b0, 1'b0);
    fill(2); run_burst(3'd0, 0, 1'b0, 1'b0, 1'b0);
    fill(3); run_burst(3'd7, longint'($urandom_range(0, 1000)), 1'b0, 1'b0, 1'b0);
    fill(4); run_burst(3'd1, longint'($urandom_range(0, 50)), 1'b1, 1'b1, 1'b0);
    fill(3); run_burst(3'd4, 5, 1'b0, 1'b0, 1'b1);
    fill(4); run_burst(3'd6, 9, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      fill((k % 2 == 0) ? 3 : 4);
      run_burst(AW'($urandom), (k == 2) ? SAT : longint'($urandom_range(0, 1 << 20)),
                k[0], 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
